syst_fir_chain: RTL and testbench

//  Parametrised N-tap systolic MAC chain: y[n] = sum_{k=0..N-1} w[k]*x[n-k], one signed sample/cycle.

---
 rtl/syst_fir_chain.sv | 171 +++++++++++++++++
 tb/tb_syst_fir_chain.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/syst_fir_chain.sv
// N-tap systolic MAC chain: y[n] = sum w[k]*x[n-k] with serially loaded coefficients,
// sample back-pressure, round-half-up shift and output saturation.
module syst_fir_chain #(
  parameter int N_TAPS    = 4,
  parameter int X_WIDTH   = 16,
  parameter int W_WIDTH   = 16,
  parameter int OUT_WIDTH = 16,
  parameter int SHIFT     = 0
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        enable,
  input  logic                        w_load_i,
  input  logic signed [W_WIDTH-1:0]   w_i,
  input  logic signed [X_WIDTH-1:0]   x_i,
  input  logic                        x_valid_i,
  output logic                        x_ready_o,
  output logic signed [OUT_WIDTH-1:0] y_o,
  output logic                        y_valid_o,
  output logic                        sat_o,
  output logic                        coef_ok_o
);

  localparam int PW        = X_WIDTH + W_WIDTH;
  localparam int ACC_WIDTH = PW + $clog2(N_TAPS);
  localparam int RW        = ACC_WIDTH + 1;
  localparam int CW        = $clog2(N_TAPS + 1);
  localparam longint OMAX_L = (longint'(1) <<< (OUT_WIDTH - 1)) - 1;
  localparam logic signed [RW-1:0] OMAX = RW'(OMAX_L);
  localparam logic signed [RW-1:0] OMIN = RW'(-OMAX_L - 1);

  typedef enum logic [1:0] {EMPTY, LOAD, RUN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            coef_ok_q, coef_ok_d;
  logic            shift_w, flush, accept;
  logic [1:0]      vld_q;
  logic            y_valid_q, sat_q, sat_d;
  logic signed [OUT_WIDTH-1:0] y_q, y_d;
  logic signed [PW-1:0]        prod_out [N_TAPS];
  logic signed [RW-1:0]        sum_d, r_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    coef_ok_d = coef_ok_q;
    shift_w   = 1'b0;
    flush     = 1'b0;
    case (state_q)
      EMPTY: if (w_load_i) begin
        state_d = LOAD;
        cnt_d   = CW'(1);
        shift_w = 1'b1;
      end
      LOAD: if (w_load_i) begin
        shift_w = 1'b1;
        if (cnt_q == CW'(N_TAPS - 1)) begin
          state_d   = RUN;
          cnt_d     = CW'(N_TAPS);
          coef_ok_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RUN: if (w_load_i) begin
        // Reload restarts the coefficient set and drops everything in flight.
        state_d   = LOAD;
        cnt_d     = CW'(1);
        coef_ok_d = 1'b0;
        shift_w   = 1'b1;
        flush     = 1'b1;
      end
      default: state_d = EMPTY;
    endcase
  end

  assign x_ready_o = enable & ~w_load_i & (state_q == RUN);
  assign accept    = x_ready_o & x_valid_i;

  genvar gi;
  generate
    for (gi = 0; gi < N_TAPS; gi++) begin : g_pe
      logic signed [W_WIDTH-1:0] w_q, w_in;
      logic signed [X_WIDTH-1:0] x_q, x_in;
      logic signed [PW-1:0]      prod_q;

      if (gi == 0) begin : g_head
        assign w_in = w_i;
        assign x_in = x_i;
      end else begin : g_link
        assign w_in = g_pe[gi-1].w_q;
        assign x_in = g_pe[gi-1].x_q;
      end

      always_ff @(posedge clk) begin
        if (!rstn) begin
          w_q    <= '0;
          x_q    <= '0;
          prod_q <= '0;
        end else if (enable) begin
          if (shift_w) w_q <= w_in;
          if (flush) x_q <= '0;
          else if (accept) x_q <= x_in;
          prod_q <= PW'(w_q) * PW'(x_q);
        end
      end

      assign prod_out[gi] = prod_q;
    end
  endgenerate

  always_comb begin
    sum_d = '0;
    for (int k = 0; k < N_TAPS; k++) sum_d = sum_d + RW'(prod_out[k]);
  end

  generate
    if (SHIFT > 0) begin : g_round
      localparam logic signed [RW-1:0] HALF = RW'(1) <<< (SHIFT - 1);
      assign r_d = (sum_d + HALF) >>> SHIFT;
    end else begin : g_noround
      assign r_d = sum_d;
    end
  endgenerate

  always_comb begin
    y_d   = r_d[OUT_WIDTH-1:0];
    sat_d = 1'b0;
    if (r_d > OMAX) begin
      y_d   = OMAX[OUT_WIDTH-1:0];
      sat_d = 1'b1;
    end else if (r_d < OMIN) begin
      y_d   = OMIN[OUT_WIDTH-1:0];
      sat_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= EMPTY;
      cnt_q     <= '0;
      coef_ok_q <= 1'b0;
      vld_q     <= '0;
      y_valid_q <= 1'b0;
      y_q       <= '0;
      sat_q     <= 1'b0;
    end else if (enable) begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      coef_ok_q <= coef_ok_d;
      if (flush) begin
        vld_q     <= '0;
        y_valid_q <= 1'b0;
      end else begin
        vld_q     <= {vld_q[0], accept};
        y_valid_q <= vld_q[1];
        if (vld_q[1]) begin
          y_q   <= y_d;
          sat_q <= sat_d;
        end
      end
    end
  end

  assign y_o       = y_q;
  assign y_valid_o = y_valid_q;
  assign sat_o     = sat_q;
  assign coef_ok_o = coef_ok_q;

endmodule

// File: tb/tb_syst_fir_chain.sv
// Directed bench for syst_fir_chain: two instances (SHIFT=0 and SHIFT=1) share all inputs.
module tb_syst_fir_chain;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn, enable, w_load_i, x_valid_i;
  logic signed [15:0] w_i, x_i;
  logic x_ready_o, y_valid_o, sat_o, coef_ok_o;
  logic signed [15:0] y_o;
  logic x_ready1, y_valid1, sat1, coef_ok1;
  logic signed [15:0] y1;

  syst_fir_chain #(.N_TAPS(4), .X_WIDTH(16), .W_WIDTH(16), .OUT_WIDTH(16), .SHIFT(0)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .w_load_i(w_load_i), .w_i(w_i),
    .x_i(x_i), .x_valid_i(x_valid_i), .x_ready_o(x_ready_o), .y_o(y_o),
    .y_valid_o(y_valid_o), .sat_o(sat_o), .coef_ok_o(coef_ok_o));

  syst_fir_chain #(.N_TAPS(4), .X_WIDTH(16), .W_WIDTH(16), .OUT_WIDTH(16), .SHIFT(1)) dut1 (
    .clk(clk), .rstn(rstn), .enable(enable), .w_load_i(w_load_i), .w_i(w_i),
    .x_i(x_i), .x_valid_i(x_valid_i), .x_ready_o(x_ready1), .y_o(y1),
    .y_valid_o(y_valid1), .sat_o(sat1), .coef_ok_o(coef_ok1));

  int chk_cnt = 0;
  int pass_cnt = 0;

  // Capture of accepts and outputs, timestamped in enabled edges.
  int en_edges = 0;
  logic pre_acc, pre_en;
  int aq[$], oq[$];
  logic signed [15:0] yq[$], y1q[$];
  logic sq[$];

  always @(negedge clk) begin
    pre_acc = enable & x_valid_i & x_ready_o;
    pre_en  = enable;
  end

  always @(posedge clk) begin
    #1;
    if (pre_en) begin
      en_edges++;
      if (pre_acc) aq.push_back(en_edges);
      if (y_valid_o) begin
        oq.push_back(en_edges);
        yq.push_back(y_o);
        sq.push_back(sat_o);
        y1q.push_back(y1);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic clear_caps();
    aq.delete(); oq.delete(); yq.delete(); y1q.delete(); sq.delete();
  endtask

  task automatic load_w(input logic signed [15:0] a, b, c, d);
    logic signed [15:0] v [4];
    v = '{a, b, c, d};
    for (int i = 0; i < 4; i++) begin
      w_load_i = 1'b1; w_i = v[i];
      tick(1);
    end
    w_load_i = 1'b0;
  endtask

  task automatic send(input logic signed [15:0] v);
    x_valid_i = 1'b1; x_i = v;
    tick(1);
    x_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rstn = 1'b0; enable = 1'b1; w_load_i = 1'b0; x_valid_i = 1'b0; w_i = '0; x_i = '0;
    tick(3);
    chk_cnt++; if (y_o !== 16'sd0) $display("FAIL reset_y: got %0d expected 0", y_o); else pass_cnt++;
    chk_cnt++; if (y_valid_o !== 1'b0) $display("FAIL reset_yvalid: got %b expected 0", y_valid_o); else pass_cnt++;
    chk_cnt++; if (sat_o !== 1'b0) $display("FAIL reset_sat: got %b expected 0", sat_o); else pass_cnt++;
    chk_cnt++; if (coef_ok_o !== 1'b0) $display("FAIL reset_coef_ok: got %b expected 0", coef_ok_o); else pass_cnt++;
    chk_cnt++; if (x_ready_o !== 1'b0) $display("FAIL reset_x_ready: got %b expected 0", x_ready_o); else pass_cnt++;
    rstn = 1'b1;
    tick(1);
  endtask

  task automatic test_impulse();
    logic signed [15:0] wv [4];
    int xs [5];
    int ey [5];
    int ey1 [5];
    wv = '{16'sd4, 16'sd3, 16'sd2, 16'sd1};
    xs = '{1, 0, 0, 0, 0};
    ey = '{1, 2, 3, 4, 0};
    ey1 = '{1, 1, 2, 2, 0};
    for (int i = 0; i < 4; i++) begin
      w_load_i = 1'b1; w_i = wv[i]; x_valid_i = 1'b1; x_i = 16'sd9;
      #1;
      chk_cnt++; if (x_ready_o !== 1'b0) $display("FAIL load_x_ready beat%0d: got %b expected 0", i, x_ready_o); else pass_cnt++;
      tick(1);
      chk_cnt++; if (coef_ok_o !== (i == 3)) $display("FAIL load_coef_ok beat%0d: got %b expected %b", i, coef_ok_o, (i == 3)); else pass_cnt++;
    end
    w_load_i = 1'b0; x_valid_i = 1'b0;
    #1;
    chk_cnt++; if (x_ready_o !== 1'b1) $display("FAIL run_x_ready: got %b expected 1", x_ready_o); else pass_cnt++;
    clear_caps();
    for (int i = 0; i < 5; i++) send(16'(xs[i]));
    tick(4);
    chk_cnt++; if (yq.size() != 5) $display("FAIL impulse_count: got %0d expected 5", yq.size()); else pass_cnt++;
    for (int i = 0; i < 5 && i < yq.size(); i++) begin
      chk_cnt++; if (yq[i] !== 16'(ey[i])) $display("FAIL impulse_y%0d: got %0d expected %0d", i, yq[i], ey[i]); else pass_cnt++;
      chk_cnt++; if (y1q[i] !== 16'(ey1[i])) $display("FAIL impulse_round_y%0d: got %0d expected %0d", i, y1q[i], ey1[i]); else pass_cnt++;
      chk_cnt++; if (sq[i] !== 1'b0) $display("FAIL impulse_sat%0d: got %b expected 0", i, sq[i]); else pass_cnt++;
      chk_cnt++; if (oq[i] - aq[i] != 2) $display("FAIL impulse_latency%0d: got %0d expected 2", i, oq[i] - aq[i]); else pass_cnt++;
    end
  endtask

  task automatic test_gaps();
    int ey [4];
    ey = '{1, 2, 3, 4};
    clear_caps();
    send(16'sd1); tick(3);
    send(16'sd0); tick(3);
    send(16'sd0); tick(3);
    send(16'sd0); tick(4);
    chk_cnt++; if (yq.size() != 4) $display("FAIL gaps_count: got %0d expected 4", yq.size()); else pass_cnt++;
    for (int i = 0; i < 4 && i < yq.size(); i++) begin
      chk_cnt++; if (yq[i] !== 16'(ey[i])) $display("FAIL gaps_y%0d: got %0d expected %0d", i, yq[i], ey[i]); else pass_cnt++;
      chk_cnt++; if (oq[i] - aq[i] != 2) $display("FAIL gaps_latency%0d: got %0d expected 2", i, oq[i] - aq[i]); else pass_cnt++;
    end
  endtask

  task automatic test_round();
    int xs [3];
    int ey [3];
    int ey1 [3];
    xs = '{1, -1, -2};
    ey = '{3, -3, -6};
    ey1 = '{2, -1, -3};
    load_w(16'sd0, 16'sd0, 16'sd0, 16'sd3);
    clear_caps();
    for (int i = 0; i < 3; i++) send(16'(xs[i]));
    tick(4);
    chk_cnt++; if (y1q.size() != 3) $display("FAIL round_count: got %0d expected 3", y1q.size()); else pass_cnt++;
    for (int i = 0; i < 3 && i < y1q.size(); i++) begin
      chk_cnt++; if (y1q[i] !== 16'(ey1[i])) $display("FAIL round_shift1_y%0d: got %0d expected %0d", i, y1q[i], ey1[i]); else pass_cnt++;
      chk_cnt++; if (yq[i] !== 16'(ey[i])) $display("FAIL round_shift0_y%0d: got %0d expected %0d", i, yq[i], ey[i]); else pass_cnt++;
    end
  endtask

  task automatic test_sat();
    int ey [8];
    ey = '{32767, 32767, 32767, 32767, 32767, -32768, -32768, -32768};
    load_w(16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767);
    clear_caps();
    for (int i = 0; i < 4; i++) send(16'sd32767);
    for (int i = 0; i < 4; i++) send(-16'sd32768);
    tick(4);
    chk_cnt++; if (yq.size() != 8) $display("FAIL sat_count: got %0d expected 8", yq.size()); else pass_cnt++;
    for (int i = 0; i < 8 && i < yq.size(); i++) begin
      chk_cnt++; if (yq[i] !== 16'(ey[i])) $display("FAIL sat_y%0d: got %0d expected %0d", i, yq[i], ey[i]); else pass_cnt++;
      chk_cnt++; if (sq[i] !== 1'b1) $display("FAIL sat_flag%0d: got %b expected 1", i, sq[i]); else pass_cnt++;
    end
  endtask

  task automatic test_reload();
    logic signed [15:0] wv [3];
    int ey [4];
    wv = '{16'sd30, 16'sd20, 16'sd10};
    ey = '{10, 20, 30, 40};
    load_w(16'sd4, 16'sd3, 16'sd2, 16'sd1);
    clear_caps();
    send(16'sd5);
    w_load_i = 1'b1; w_i = 16'sd40; x_valid_i = 1'b1; x_i = 16'sd7;
    #1;
    chk_cnt++; if (x_ready_o !== 1'b0) $display("FAIL reload_x_ready: got %b expected 0", x_ready_o); else pass_cnt++;
    tick(1);
    x_valid_i = 1'b0;
    chk_cnt++; if (coef_ok_o !== 1'b0) $display("FAIL reload_coef_ok_drop: got %b expected 0", coef_ok_o); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      w_i = wv[i];
      tick(1);
    end
    w_load_i = 1'b0;
    chk_cnt++; if (coef_ok_o !== 1'b1) $display("FAIL reload_coef_ok_set: got %b expected 1", coef_ok_o); else pass_cnt++;
    tick(4);
    chk_cnt++; if (yq.size() != 0) $display("FAIL reload_flush: got %0d outputs expected 0", yq.size()); else pass_cnt++;
    clear_caps();
    send(16'sd1); send(16'sd0); send(16'sd0); send(16'sd0);
    tick(4);
    chk_cnt++; if (yq.size() != 4) $display("FAIL reload_count: got %0d expected 4", yq.size()); else pass_cnt++;
    for (int i = 0; i < 4 && i < yq.size(); i++) begin
      chk_cnt++; if (yq[i] !== 16'(ey[i])) $display("FAIL reload_y%0d: got %0d expected %0d", i, yq[i], ey[i]); else pass_cnt++;
    end
  endtask

  task automatic test_enable();
    clear_caps();
    send(16'sd2);
    enable = 1'b0; x_valid_i = 1'b1; x_i = 16'sd9;
    #1;
    chk_cnt++; if (x_ready_o !== 1'b0) $display("FAIL freeze_x_ready: got %b expected 0", x_ready_o); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      chk_cnt++; if (y_valid_o !== 1'b0 || y_o !== 16'sd40) $display("FAIL freeze_hold%0d: got v=%b y=%0d expected v=0 y=40", i, y_valid_o, y_o); else pass_cnt++;
    end
    x_valid_i = 1'b0; enable = 1'b1;
    tick(1);
    chk_cnt++; if (y_valid_o !== 1'b0) $display("FAIL freeze_early: got %b expected 0", y_valid_o); else pass_cnt++;
    tick(1);
    chk_cnt++; if (y_valid_o !== 1'b1 || y_o !== 16'sd20) $display("FAIL freeze_result: got v=%b y=%0d expected v=1 y=20", y_valid_o, y_o); else pass_cnt++;
    enable = 1'b0;
    tick(3);
    chk_cnt++; if (y_valid_o !== 1'b1 || y_o !== 16'sd20 || coef_ok_o !== 1'b1) $display("FAIL freeze_valid_hold: got v=%b y=%0d ok=%b expected v=1 y=20 ok=1", y_valid_o, y_o, coef_ok_o); else pass_cnt++;
    enable = 1'b1;
    tick(1);
    chk_cnt++; if (y_valid_o !== 1'b0) $display("FAIL freeze_one_shot: got %b expected 0", y_valid_o); else pass_cnt++;
    chk_cnt++; if (yq.size() != 1 || oq[0] - aq[0] != 2) $display("FAIL freeze_latency: got n=%0d lat=%0d expected n=1 lat=2", yq.size(), oq[0] - aq[0]); else pass_cnt++;
  endtask

  task automatic test_reset_in_load();
    w_load_i = 1'b1; w_i = 16'sd5;
    tick(2);
    w_load_i = 1'b0; enable = 1'b0; rstn = 1'b0;
    tick(1);
    enable = 1'b1;
    #1;
    chk_cnt++; if (coef_ok_o !== 1'b0) $display("FAIL load_reset_coef_ok: got %b expected 0", coef_ok_o); else pass_cnt++;
    chk_cnt++; if (x_ready_o !== 1'b0) $display("FAIL load_reset_x_ready: got %b expected 0", x_ready_o); else pass_cnt++;
    chk_cnt++; if (y_o !== 16'sd0) $display("FAIL load_reset_y: got %0d expected 0", y_o); else pass_cnt++;
    rstn = 1'b1;
    tick(1);
    chk_cnt++; if (x_ready_o !== 1'b0) $display("FAIL load_reset_empty: got %b expected 0", x_ready_o); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      w_load_i = 1'b1; w_i = 16'sd1;
      tick(1);
      chk_cnt++; if (coef_ok_o !== (i == 3)) $display("FAIL load_reset_count beat%0d: got %b expected %b", i, coef_ok_o, (i == 3)); else pass_cnt++;
    end
    w_load_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_gaps();
    test_round();
    test_sat();
    test_reload();
    test_enable();
    test_reset_in_load();
    tick(2);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
